seq_playback_ctrl: RTL and testbench
====================================

# seq_playback_ctrl

Sequences playback of the stored Simon pattern for the game controller. On `start`, it walks the sequence memory from address 0 to `len-1` and lights one LED per stored colour for a fixed on-time, followed by a dark gap. It pulses `done` when the last element has been shown. It sits between the game FSM, which issues `start`/`abort`, and the shared sequence RAM plus LED outputs, replacing the one-cycle-per-element playback.

## Interface
- `ADDR_W`, 5: sequence memory address width; maximum sequence length is 2^ADDR_W.
- `ON_CYCLES`, 25_000_000: clock cycles each LED is lit (≥1).
- `OFF_CYCLES`, 12_500_000: dark-gap cycles after each LED (≥1).
- `CNT_W`, 25: timer width; must hold max(ON_CYCLES, OFF_CYCLES)-1.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to begin playback; honoured only in IDLE.
- `abort` in 1: stop playback immediately; no `done` is issued.
- `len` in ADDR_W+1: number of elements to play; sampled with `start`.
- `mem_data` in 2: colour index; valid the cycle after `mem_rd`.
- `mem_addr` out ADDR_W: read address.
- `mem_rd` out 1: read strobe.
- `led` out 4: one-hot lit LED; 0 when dark.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of playback.

## Operation
- Moore FSM with states IDLE, FETCH, WAIT_DATA, ON, OFF, DONE.
- Registers:
  - `idx` (ADDR_W+1): current element.
  - `len_q`: length latched at start.
  - `color_q` (2): colour of the current element.
  - `timer` (CNT_W).
- IDLE:
  - If `start` and not `abort`, latch `len_q = min(len, 2^ADDR_W)`.
  - If `len_q` is nonzero, set `idx=0` and go to FETCH.
  - If `len` is 0, go straight to DONE.
- FETCH: drive `mem_rd=1` and `mem_addr=idx[ADDR_W-1:0]` for exactly one cycle, then go to WAIT_DATA.
- WAIT_DATA: latch `color_q=mem_data`, load `timer=ON_CYCLES-1`, go to ON.
- ON:
  - `led = 1<<color_q`.
  - At `timer==0`, load `timer=OFF_CYCLES-1` and go to OFF; otherwise decrement.
- OFF:
  - `led=0`.
  - At `timer==0`: if `idx==len_q-1` go to DONE, else increment `idx` and go to FETCH.
  - Otherwise decrement `timer`.
- DONE: `done=1` for one cycle, then go to IDLE.
- `abort`:
  - Sampled high in any state other than IDLE forces IDLE on the next edge.
  - `led`, `mem_rd`, `busy` and `done` are low from that edge onward.
  - `abort` has priority over `start` when both are high in IDLE, and over DONE.
- `start` while busy is ignored; `len_q` is not re-latched.
- `mem_addr` holds `idx` in every state; `mem_rd` is high only in FETCH.
- Reset: state IDLE; `idx`, `len_q`, `color_q`, `timer` are 0; all outputs are 0.
- Reset asserted mid-playback returns to IDLE immediately (asynchronous). No `done` is issued.

## Timing
- Outputs decode from registered state only; no combinational path from inputs to outputs.
- `start` sampled at edge 0:
  - FETCH in cycle 1, WAIT_DATA in cycle 2.
  - `led` lit in cycles 3 .. 2+ON_CYCLES.
  - Dark for OFF_CYCLES cycles after that.
- Per-element period: 2+ON_CYCLES+OFF_CYCLES cycles.
- `done` is high in cycle 1 + len_q·(2+ON_CYCLES+OFF_CYCLES).
- With `len=0`, `done` is high in cycle 1.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new `start` is accepted in the cycle after DONE (IDLE), so playbacks can run back-to-back with a 1-cycle IDLE gap.
- Memory read latency is fixed at 1 cycle; no other handshake.

## Test plan
Unless stated, ON_CYCLES=4, OFF_CYCLES=2, ADDR_W=5, and memory holds colours 2,0,3,1 at addresses 0..3.
- Single-element play, `len=1`: `mem_rd` high in cycle 1 with addr 0; `led=4'b0100` in cycles 3–6; `led=0` in cycles 7–8; `done` high in cycle 9 only; `busy` high in cycles 1–9.
- Four-element play, `len=4`: `led` shows 0100, 0001, 1000, 0010 in order, each for 4 cycles with 2 dark cycles between; `mem_addr` steps 0,1,2,3; `done` high in cycle 33.
- `len=0`: `done` high in cycle 1; `mem_rd` never asserted; `led` stays 0.
- Abort at cycle 12 during `len=4`: IDLE from cycle 13; `led`, `busy` and `done` stay 0 afterward; a following `start` with `len=2` replays from address 0.
- `start` pulsed at cycle 5 with `len=7` while playing `len=1`: ignored; `done` still high at cycle 9; `len_q` remains 1.
- `rst` driven low asynchronously mid-ON: all outputs 0 before the next clock edge; after release, no `done` pulse and `busy=0`. Separately, `len=40` clamps to 32: `mem_addr` reaches 31 and `done` is high in cycle 1+32·8=257.

Source files
------------

// File: rtl/seq_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_playback_ctrl
//  Purpose  : Plays back the stored Simon pattern. On start it walks the
//             sequence RAM from address 0 to len-1. Each stored colour lights
//             one LED for ON_CYCLES clocks, then the LEDs go dark for
//             OFF_CYCLES clocks. done pulses after the last element.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-low reset
//             start    - one-cycle playback request (IDLE only)
//             abort    - stop playback at once, no done
//             len      - elements to play, sampled with start
//             mem_data - colour index, valid the cycle after mem_rd
//             mem_addr - sequence RAM read address
//             mem_rd   - sequence RAM read strobe
//             led      - one-hot lit LED, 0 when dark
//             busy     - high whenever not IDLE
//             done     - one-cycle end-of-playback pulse
//  Revision : 1.0 - initial release
// ============================================================================
module seq_playback_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CNT_W      = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [1:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_ON        = 3'd3,
        S_OFF       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_on_load   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_off_load  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timer_one = CNT_W'(1);
    localparam logic [ADDR_W:0]  c_len_max   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  c_idx_one   = {{ADDR_W{1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W:0]    r_idx;
    logic [ADDR_W:0]    w_idx_nxt;
    logic [ADDR_W:0]    r_len_q;
    logic [ADDR_W:0]    w_len_nxt;
    logic [1:0]         r_color_q;
    logic [1:0]         w_color_nxt;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_last;

    // len_q is never zero while elements are being shown, so len_q-1 cannot wrap here.
    assign w_last = (r_idx == (r_len_q - c_idx_one));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len_q   <= '0;
            r_color_q <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_len_q   <= w_len_nxt;
            r_color_q <= w_color_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len_q;
        w_color_nxt = r_color_q;
        w_timer_nxt = r_timer;

        // Abort outranks every transition, including the exit from OFF into DONE.
        if ((r_state != S_IDLE) && abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        // Anything longer than the RAM is clamped to its full depth.
                        w_len_nxt = (len > c_len_max) ? c_len_max : len;
                        if (len == '0) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    w_color_nxt = mem_data;
                    w_timer_nxt = c_on_load;
                    w_state_nxt = S_ON;
                end
                S_ON: begin
                    if (r_timer == '0) begin
                        w_timer_nxt = c_off_load;
                        w_state_nxt = S_OFF;
                    end else begin
                        w_timer_nxt = r_timer - c_timer_one;
                    end
                end
                S_OFF: begin
                    if (r_timer == '0) begin
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + c_idx_one;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_timer_nxt = r_timer - c_timer_one;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs: decoded from registered state only.
    always_comb begin
        led      = 4'b0000;
        mem_rd   = 1'b0;
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        mem_addr = r_idx[ADDR_W-1:0];
        if (r_state == S_ON) begin
            led = 4'b0001 << r_color_q;
        end
        if (r_state == S_FETCH) begin
            mem_rd = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_playback_ctrl
//  Purpose  : Directed self-checking bench for seq_playback_ctrl with
//             ON_CYCLES=4, OFF_CYCLES=2, ADDR_W=5 and RAM colours 2,0,3,1
//             at addresses 0..3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_playback_ctrl;

    localparam int ADDR_W = 5;
    localparam int ON_C   = 4;
    localparam int OFF_C  = 2;
    localparam int CNT_W  = 25;
    localparam int PER    = 2 + ON_C + OFF_C;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   len;
    logic [1:0]        mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [3:0]        led;
    logic              busy;
    logic              done;

    logic [1:0] mem [0:31];

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [3:0]        led;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              done;
    } obs_t;

    seq_playback_ctrl #(
        .ADDR_W    (ADDR_W),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .mem_data(mem_data),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Expected outputs in cycle c of a playback of L elements (start sampled at edge 0).
    function automatic obs_t model(input int c, input int L);
        obs_t x;
        int   e;
        int   p;
        int   last;
        x = '0;
        if (L == 0) begin
            x.busy = (c == 1);
            x.done = (c == 1);
        end else if (c <= PER * L) begin
            e      = (c - 1) / PER;
            p      = (c - 1) % PER;
            x.busy = 1'b1;
            x.addr = e[ADDR_W-1:0];
            x.rd   = (p == 0);
            if (p >= 2 && p < 2 + ON_C) x.led = 4'b0001 << mem[e];
        end else begin
            last   = L - 1;
            x.addr = last[ADDR_W-1:0];
            if (c == PER * L + 1) begin
                x.busy = 1'b1;
                x.done = 1'b1;
            end
        end
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x.led  = led;
        x.rd   = mem_rd;
        x.addr = mem_addr;
        x.busy = busy;
        x.done = done;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int L);
        start = 1'b1;
        len   = L[ADDR_W:0];
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t ob;
        rst = 1'b0;
        tick();
        tick();
        ob = sample();
        n_cmp++;
        if (ob !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_held got %h want 0", ob);
        end
        rst = 1'b1;
        tick();
        ob = sample();
        n_cmp++;
        if (ob !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_released got %h want 0", ob);
        end
    endtask

    task automatic test_zero_len();
        obs_t ob;
        obs_t ex;
        launch(0);
        for (int c = 1; c <= 3; c++) begin
            ex      = model(c, 0);
            ob      = sample();
            ob.addr = '0;
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL zero_len c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
    endtask

    task automatic test_single();
        obs_t ob;
        obs_t ex;
        launch(1);
        for (int c = 1; c <= 10; c++) begin
            ex = model(c, 1);
            ob = sample();
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL single c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
    endtask

    task automatic test_four();
        obs_t ob;
        obs_t ex;
        launch(4);
        for (int c = 1; c <= 34; c++) begin
            ex = model(c, 4);
            ob = sample();
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL four c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        obs_t ob;
        obs_t ex;
        launch(1);
        for (int c = 1; c <= 13; c++) begin
            ex = model(c, 1);
            ob = sample();
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL busy_start c=%0d got %h want %h", c, ob, ex);
            end
            if (c == 5) begin
                start = 1'b1;
                len   = 7'd7;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_abort();
        obs_t ob;
        obs_t ex;
        launch(4);
        for (int c = 1; c <= 20; c++) begin
            ob = sample();
            if (c <= 12) begin
                ex = model(c, 4);
            end else begin
                ex      = '0;
                ob.addr = '0;
            end
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL abort c=%0d got %h want %h", c, ob, ex);
            end
            if (c == 12) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        launch(2);
        for (int c = 1; c <= 18; c++) begin
            ex = model(c, 2);
            ob = sample();
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL abort_replay c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob;
        obs_t ex;
        launch(1);
        for (int c = 1; c <= 9; c++) tick();
        // Now in the IDLE cycle right after DONE.
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap busy=%b done=%b want 0 0", busy, done);
        end
        launch(2);
        for (int c = 1; c <= 18; c++) begin
            ex = model(c, 2);
            ob = sample();
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL b2b c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        obs_t ob;
        launch(2);
        for (int c = 1; c <= 3; c++) tick();
        n_cmp++;
        if (led !== 4'b0100) begin
            n_err++;
            $display("FAIL arst_pre_led got %b want 0100", led);
        end
        #2;
        rst = 1'b0;
        #1;
        ob = sample();
        n_cmp++;
        if (ob !== obs_t'(0)) begin
            n_err++;
            $display("FAIL arst_immediate got %h want 0", ob);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            ob = sample();
            n_cmp++;
            if (ob !== obs_t'(0)) begin
                n_err++;
                $display("FAIL arst_after c=%0d got %h want 0", c, ob);
            end
        end
    endtask

    task automatic test_clamp();
        obs_t ob;
        obs_t ex;
        int   max_addr;
        max_addr = 0;
        launch(40);
        for (int c = 1; c <= 258; c++) begin
            ex = model(c, 32);
            ob = sample();
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL clamp c=%0d got %h want %h", c, ob, ex);
            end
            tick();
        end
        n_cmp++;
        if (max_addr != 31) begin
            n_err++;
            $display("FAIL clamp_max_addr got %0d want 31", max_addr);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        len   = '0;
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        mem[3] = 2'd1;
        for (int i = 4; i < 32; i++) mem[i] = 2'(i % 4);
        #1;

        test_reset();
        test_zero_len();
        test_single();
        test_four();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_clamp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
